// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray-code receive tracker.
//   state_t       - tracker FSM states (IDLE, TRACK, FAULT)
//   GRAY_WIDTH    - default Gray/binary bus width
package gray_pkg;

    localparam int GRAY_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

endpackage : gray_pkg

// File: rtl/gray2bin.sv
// gray2bin: purely combinational Gray-to-binary decoder.
// Ports:
//   gray  in  WIDTH  Gray-coded value
//   bin   out WIDTH  binary equivalent
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it; writing it
    // as a reduction avoids a ripple through the output vector itself.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin[gi] = ^gray[WIDTH-1:gi];
    end

endmodule : gray2bin

// File: rtl/gray_tracker.sv
// gray_tracker: samples a Gray-coded count bus, decodes it and checks that
// each new sample is unchanged or exactly one forward step (mod 2^WIDTH).
// Illegal jumps latch Error and freeze the tracker until Clear/Reset;
// an accepted top-to-zero step latches Wrap.
//
// Ports:
//   Clk        in   1            rising-edge clock
//   Reset      in   1            synchronous active-high reset
//   Valid      in   1            GrayIn is sampled this cycle
//   GrayIn     in   WIDTH        Gray-coded count
//   Clear      in   1            clears Error/Wrap/StepCount, back to IDLE
//   Binary     out  WIDTH        last accepted value (binary)
//   Step       out  1            one-cycle pulse per accepted forward step
//   Wrap       out  1            sticky wrap-around flag
//   Error      out  1            sticky illegal-transition flag
//   StepCount  out  COUNT_WIDTH  saturating count of accepted steps
//
// Build option: GRAY_TRACKER_COUNT_EN builds the StepCount counter; when
// undefined, StepCount is tied to zero and the port list is unchanged.
module gray_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_WIDTH,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Valid,
    input  logic [WIDTH-1:0]       GrayIn,
    input  logic                   Clear,
    output logic [WIDTH-1:0]       Binary,
    output logic                   Step,
    output logic                   Wrap,
    output logic                   Error,
    output logic [COUNT_WIDTH-1:0] StepCount
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] binary_reg, binary_next;
    logic             step_reg, step_next;
    logic             wrap_reg, wrap_next;
    logic             error_reg, error_next;

    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] successor;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (GrayIn),
        .bin  (decoded)
    );

    // WIDTH-bit add, so the top code naturally rolls over to zero.
    assign successor = binary_reg + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_next  = state_reg;
        binary_next = binary_reg;
        step_next   = 1'b0;
        wrap_next   = wrap_reg;
        error_next  = error_reg;

        // Clear outranks any sample arriving in the same cycle; Binary holds.
        if (Clear) begin
            state_next = IDLE;
            wrap_next  = 1'b0;
            error_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // First sample only establishes the reference value.
                    if (Valid) begin
                        binary_next = decoded;
                        state_next  = TRACK;
                    end
                end
                TRACK: begin
                    if (Valid && (decoded != binary_reg)) begin
                        if (decoded == successor) begin
                            binary_next = decoded;
                            step_next   = 1'b1;
                            if (binary_reg == {WIDTH{1'b1}}) begin
                                wrap_next = 1'b1;
                            end
                        end else begin
                            error_next = 1'b1;
                            state_next = FAULT;
                        end
                    end
                end
                FAULT: begin
                    error_next = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= IDLE;
            binary_reg <= '0;
            step_reg   <= 1'b0;
            wrap_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            binary_reg <= binary_next;
            step_reg   <= step_next;
            wrap_reg   <= wrap_next;
            error_reg  <= error_next;
        end
    end

`ifdef GRAY_TRACKER_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_reg;

    // step_next is high exactly when a forward step is accepted.
    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            count_reg <= '0;
        end else if (step_next && (count_reg != {COUNT_WIDTH{1'b1}})) begin
            count_reg <= count_reg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign StepCount = count_reg;
`else
    assign StepCount = '0;
`endif

    assign Binary = binary_reg;
    assign Step   = step_reg;
    assign Wrap   = wrap_reg;
    assign Error  = error_reg;

endmodule : gray_tracker

// File: tb/tb_gray_tracker.sv
// tb_gray_tracker: directed plus randomized stimulus for gray_tracker,
// checked every cycle against a behavioural model. Two instances share the
// stimulus: one with an 8-bit counter, one with a 2-bit counter to exercise
// saturation.
module tb_gray_tracker;

    localparam int W   = 3;
    localparam int CW  = 8;
    localparam int CWS = 2;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Valid = 1'b0;
    logic [W-1:0] GrayIn = '0;
    logic         Clear = 1'b0;

    logic [W-1:0]   bin_a, bin_b;
    logic           step_a, step_b, wrap_a, wrap_b, err_a, err_b;
    logic [CW-1:0]  cnt_a;
    logic [CWS-1:0] cnt_b;

    gray_tracker #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .Clear(Clear),
        .Binary(bin_a), .Step(step_a), .Wrap(wrap_a), .Error(err_a), .StepCount(cnt_a)
    );

    gray_tracker #(.WIDTH(W), .COUNT_WIDTH(CWS)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .Clear(Clear),
        .Binary(bin_b), .Step(step_b), .Wrap(wrap_b), .Error(err_b), .StepCount(cnt_b)
    );

    always #5 Clk = ~Clk;

`ifdef GRAY_TRACKER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: "seen a reference yet", "frozen after an error",
    // last accepted value and an unbounded step tally.
    bit m_have_ref, m_frozen, m_step, m_wrap, m_err;
    int m_bin, m_steps;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int to_gray(input int v);
        return (v ^ (v >> 1)) % (1 << W);
    endfunction

    function automatic int from_gray(input int g);
        int b = g;
        for (int s = 1; s < W; s = s * 2) b = b ^ (b >> s);
        return b % (1 << W);
    endfunction

    function automatic int sat(input int n, input int cw);
        int top = (1 << cw) - 1;
        if (!COUNT_EN) return 0;
        return (n > top) ? top : n;
    endfunction

    task automatic model_step(input bit v, input int g, input bit c, input bit r);
        int d = from_gray(g);
        m_step = 1'b0;
        if (r) begin
            m_have_ref = 0; m_frozen = 0; m_wrap = 0; m_err = 0; m_bin = 0; m_steps = 0;
        end else if (c) begin
            m_have_ref = 0; m_frozen = 0; m_wrap = 0; m_err = 0; m_steps = 0;
        end else if (m_frozen || !v) begin
            // nothing changes
        end else if (!m_have_ref) begin
            m_have_ref = 1; m_bin = d;
        end else if (d == m_bin) begin
            // repeat sample
        end else if (d == (m_bin + 1) % (1 << W)) begin
            if (m_bin == (1 << W) - 1) m_wrap = 1;
            m_bin = d; m_step = 1; m_steps++;
        end else begin
            m_err = 1; m_frozen = 1;
        end
    endtask

    task automatic do_cycle(input bit v, input int g, input bit c, input bit r);
        @(negedge Clk);
        Valid = v; GrayIn = W'(g); Clear = c; Reset = r;
        @(posedge Clk);
        model_step(v, g, c, r);
        #1;
        cyc++;
        $display("cyc=%0d r=%0b c=%0b v=%0b g=%03b | bin=%0d step=%0b wrap=%0b err=%0b cnt=%0d sat=%0d",
                 cyc, r, c, v, W'(g), bin_a, step_a, wrap_a, err_a, cnt_a, cnt_b);
        check_val("binary",  int'(bin_a),  m_bin);
        check_val("step",    int'(step_a), int'(m_step));
        check_val("wrap",    int'(wrap_a), int'(m_wrap));
        check_val("error",   int'(err_a),  int'(m_err));
        check_val("count",   int'(cnt_a),  sat(m_steps, CW));
        check_val("binary_s", int'(bin_b), m_bin);
        check_val("step_s",  int'(step_b), int'(m_step));
        check_val("wrap_s",  int'(wrap_b), int'(m_wrap));
        check_val("error_s", int'(err_b),  int'(m_err));
        check_val("count_s", int'(cnt_b),  sat(m_steps, CWS));
    endtask

    initial begin
        int legal_seq[] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
        int wrap_seq[]  = '{3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
        int r, g;
        bit rv, cv, vv;

        // Reset: everything zero.
        do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 0, 1);
        check_val("reset_bin", int'(bin_a), 0);

        // Legal count 0..4, then walk through the wrap.
        foreach (legal_seq[i]) do_cycle(1, legal_seq[i], 0, 0);
        check_val("legal_bin", int'(bin_a), 4);
        check_val("legal_cnt", int'(cnt_a), COUNT_EN ? 4 : 0);
        check_val("legal_sat", int'(cnt_b), COUNT_EN ? 3 : 0);
        foreach (wrap_seq[i]) do_cycle(1, wrap_seq[i], 0, 0);
        check_val("wrap_sticky", int'(wrap_a), 1);
        check_val("wrap_bin", int'(bin_a), 1);

        // Repeat and gaps.
        do_cycle(0, 0, 1, 0);
        do_cycle(1, 3'b001, 0, 0);
        do_cycle(1, 3'b001, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 3'b111, 0, 0);
        do_cycle(1, 3'b011, 0, 0);
        check_val("gap_step", int'(step_a), 1);
        check_val("gap_bin", int'(bin_a), 2);

        // Illegal jump then ignored sample.
        do_cycle(0, 0, 1, 0);
        do_cycle(1, 3'b000, 0, 0);
        do_cycle(1, 3'b011, 0, 0);
        check_val("illegal_err", int'(err_a), 1);
        check_val("illegal_bin", int'(bin_a), 0);
        do_cycle(1, 3'b001, 0, 0);

        // Clear collides with a sample: sample discarded, next one is a reference.
        do_cycle(1, 3'b111, 1, 0);
        do_cycle(1, 3'b111, 0, 0);
        check_val("clear_bin", int'(bin_a), 5);
        check_val("clear_step", int'(step_a), 0);

        // Reset mid-run.
        do_cycle(1, 3'b101, 0, 0);
        do_cycle(1, 3'b101, 0, 1);
        check_val("midreset_bin", int'(bin_a), 0);

        // Randomized run.
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 99);
            rv = (r < 2);
            cv = (r >= 2 && r < 6);
            vv = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            if (r < 6)      g = to_gray(m_bin + 1);
            else if (r < 8) g = to_gray(m_bin);
            else            g = $urandom_range(0, (1 << W) - 1);
            do_cycle(vv, g, cv, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gray_tracker
